// File: rtl/boot_loader_pkg.sv
// boot_pkg: shared definitions for the boot loader.
//   boot_state_t    - loader FSM state encoding
//   BOOT_PC_INITIAL - CPU reset vector, also used by the CPU PC reset logic
//   stride()        - byte distance between consecutive instruction words
package boot_pkg;

  localparam logic [31:0] BOOT_PC_INITIAL = 32'hbfc00000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4,
    RUN   = 3'd5,
    ERROR = 3'd6
  } boot_state_t;

  function automatic int stride(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/boot_loader_cycle_counter.sv
// boot_cycle_counter: loadable down-counter with a zero flag.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   load_i         - load load_val_i (takes priority over dec_i)
//   load_val_i     - value to load
//   dec_i          - decrement by one; saturates at zero
//   zero_o         - count is zero
module boot_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams a program image into inst_ram while the CPU is held
// in reset/debug, then releases the CPU to run from BASE_ADDR.
//   clk, resetn            - clock, asynchronous active-low reset
//   start                  - pulse: begin a load (IDLE), reload (RUN/ERROR)
//   load_valid/data/last   - source word stream, load_ready back to source
//   inst_ram_write_*       - registered one-cycle write strobe, data, address
//   cpu_reset, debug       - CPU held while 1
//   done                   - CPU released and running
//   error                  - image exceeded DEPTH words without load_last
//   words_loaded           - words written in the current load
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both 1. load_ready depends only on the current state (1 in
// LOAD), never on load_valid. load_valid/data/last are ignored when no
// transfer happens, so the source may raise or drop load_valid freely.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BOOT_PC_INITIAL),
  parameter int                DEPTH       = 1024,
  parameter int                WR_GAP      = 1,
  parameter int                HOLD_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       inst_ram_write_enable,
  output logic [DATA_W-1:0]          inst_ram_write_data,
  output logic [ADDR_W-1:0]          inst_ram_write_address,
  output logic                       cpu_reset,
  output logic                       debug,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded
);

  localparam int WL_W      = $clog2(DEPTH + 1);
  localparam int STRIDE    = stride(DATA_W);
  // Counters are loaded with N-1 on entry so that GAP lasts WR_GAP cycles
  // and HOLD lasts HOLD_CYCLES cycles, leaving when the count reads zero.
  localparam int GAP_INIT  = (WR_GAP > 0) ? WR_GAP - 1 : 0;
  localparam int GAP_W     = (GAP_INIT > 0) ? $clog2(GAP_INIT + 1) : 1;
  localparam int HOLD_INIT = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0;
  localparam int HOLD_W    = (HOLD_INIT > 0) ? $clog2(HOLD_INIT + 1) : 1;

  boot_state_t       state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              debug_q, debug_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [WL_W-1:0]   words_q, words_d;
  logic              last_q, last_d;

  logic gap_load, gap_dec, gap_zero;
  logic hold_load, hold_dec, hold_zero;

  boot_cycle_counter #(.W(GAP_W)) u_gap_cnt (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_INIT)),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  boot_cycle_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .load_i     (hold_load),
    .load_val_i (HOLD_W'(HOLD_INIT)),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    cpu_reset_d = cpu_reset_q;
    debug_d     = debug_q;
    done_d      = done_q;
    error_d     = error_q;
    words_d     = words_q;
    last_d      = last_q;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    hold_load   = 1'b0;
    hold_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          words_d = '0;
          waddr_d = BASE_ADDR;
          last_d  = 1'b0;
        end
      end
      LOAD: begin
        // load_ready is 1 throughout LOAD, so load_valid alone is the accept.
        if (load_valid) begin
          state_d = WRITE;
          we_d    = 1'b1;
          wdata_d = load_data;
          waddr_d = BASE_ADDR + (ADDR_W'(words_q) * ADDR_W'(STRIDE));
          words_d = words_q + WL_W'(1);
          last_d  = load_last;
        end
      end
      WRITE: begin
        // last wins over the depth check so a full-size image is legal.
        if (last_q) begin
          state_d   = HOLD;
          hold_load = 1'b1;
        end else if (words_q == WL_W'(DEPTH)) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else if (WR_GAP > 0) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      GAP: begin
        if (gap_zero) state_d = LOAD;
        else          gap_dec = 1'b1;
      end
      HOLD: begin
        if (hold_zero) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
          debug_d     = 1'b0;
          done_d      = 1'b1;
        end else begin
          hold_dec = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          state_d     = LOAD;
          cpu_reset_d = 1'b1;
          debug_d     = 1'b1;
          done_d      = 1'b0;
          words_d     = '0;
          waddr_d     = BASE_ADDR;
          last_d      = 1'b0;
        end
      end
      ERROR: begin
        if (start) begin
          state_d = LOAD;
          error_d = 1'b0;
          words_d = '0;
          waddr_d = BASE_ADDR;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= BASE_ADDR;
      cpu_reset_q <= 1'b1;
      debug_q     <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      cpu_reset_q <= cpu_reset_d;
      debug_q     <= debug_d;
      done_q      <= done_d;
      error_q     <= error_d;
      words_q     <= words_d;
      last_q      <= last_d;
    end
  end

  assign load_ready             = (state_q == LOAD);
  assign inst_ram_write_enable  = we_q;
  assign inst_ram_write_data    = wdata_q;
  assign inst_ram_write_address = waddr_q;
  assign cpu_reset              = cpu_reset_q;
  assign debug                  = debug_q;
  assign done                   = done_q;
  assign error                  = error_q;
  assign words_loaded           = words_q;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Loads a program image into instruction RAM from a valid/ready word stream while holding the CPU in reset and debug.
- After the image is written, it releases the CPU to run from BASE_ADDR.
- Sits between a host or loader source and the CPU's inst_ram write port and reset/debug inputs.
- Generalises the fixed, hand-sequenced load to parametrised width, base, depth, write spacing and reset hold, and adds back-pressure, overflow detection and restart.

Parameters:
- DATA_W, 32, instruction word width in bits; a multiple of 8.
- ADDR_W, 32, inst_ram byte-address width.
- BASE_ADDR, 32'hbfc00000, address of the first word; CPU reset vector.
- DEPTH, 1024, maximum words per image.
- WR_GAP, 1, idle cycles with write_enable low after each write pulse; 0 allowed.
- HOLD_CYCLES, 8, cycles cpu_reset stays high after the last write; 1 or more.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins or restarts a load.
- load_valid  in  1  source word valid.
- load_data  in  DATA_W  source word.
- load_last  in  1  marks the final word of the image.
- load_ready  out  1  loader accepts a word this cycle.
- inst_ram_write_enable  out  1  one-cycle write strobe.
- inst_ram_write_data  out  DATA_W  write data.
- inst_ram_write_address  out  ADDR_W  byte address.
- cpu_reset  out  1  active-high CPU reset.
- debug  out  1  CPU debug/load mode.
- done  out  1  CPU released and running.
- error  out  1  image exceeded DEPTH.
- words_loaded  out  $clog2(DEPTH+1)  words written in the current load.

Behaviour:
- All outputs are registered except load_ready, which is 1 exactly when state==LOAD.
- Reset values:
  - state IDLE, cpu_reset=1, debug=1.
  - inst_ram_write_enable=0, data=0, address=BASE_ADDR.
  - done=0, error=0, words_loaded=0.
- States: IDLE, LOAD, WRITE, GAP, HOLD, RUN, ERROR.
- IDLE:
  - cpu_reset=1, debug=1.
  - start -> LOAD with words_loaded=0 and address pointer set to BASE_ADDR.
- LOAD:
  - Accept happens when load_valid && load_ready.
  - On the accept edge: write_data<=load_data, write_address<=BASE_ADDR + words_loaded*(DATA_W/8), write_enable<=1, words_loaded+1, capture last, go WRITE.
- WRITE (strobe high for exactly one cycle):
  - write_enable<=0.
  - Next state is chosen in this order:
    - If last was captured -> HOLD.
    - Else if words_loaded==DEPTH -> ERROR.
    - Else if WR_GAP>0 -> GAP.
    - Else -> LOAD.
  - Data and address stay stable through WRITE and GAP.
- GAP: count WR_GAP cycles, then go LOAD.
- Throughput:
  - Peak rate is one word per (2+WR_GAP) cycles.
  - With WR_GAP=0, the strobe toggles every cycle.
- HOLD: cpu_reset=1 for HOLD_CYCLES cycles counted from entry, then RUN.
- RUN:
  - On the entry edge: cpu_reset<=0, debug<=0, done<=1.
  - start -> LOAD; on that same edge cpu_reset<=1, debug<=1, done<=0, words_loaded<=0.
- ERROR:
  - error=1, cpu_reset=1, debug=1.
  - start clears error and goes to LOAD.
- start is ignored in LOAD, WRITE, GAP and HOLD.
- load_last on the DEPTH-th word is legal and goes to HOLD, not ERROR.
- Address arithmetic wraps modulo 2^ADDR_W; no special handling.
- resetn asserted at any point returns all outputs to reset values immediately.
  - A partial image is abandoned and the CPU stays held in reset.
- A load_valid without a handshake has no effect; no word is ever dropped or duplicated under back-pressure.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum boot_state_t;
  - BOOT_PC_INITIAL = 32'hbfc00000, reused by the CPU PC reset logic;
  - the function stride(DATA_W) = DATA_W/8.
- One natural sub-module, boot_cycle_counter: a loadable down-counter with a zero flag, instanced for both the GAP and HOLD counts.

Test Plan:
- Twelve-word image (32'h00000001, 32'h000F0130, 32'h00AB0130, 32'h00001001, 32'h00010820, then 7 × 32'h05421004), last on the 12th word, WR_GAP=1 -> expect:
  - 12 single-cycle strobes at 0xbfc00000 through 0xbfc0002c, each 3 cycles apart;
  - cpu_reset falls 8 cycles after the 12th strobe's WRITE cycle, with done=1 and words_loaded=12.
- Back-pressure: load_valid toggles randomly with the same image -> identical write sequence; no duplicated or missing addresses.
- Overflow: DEPTH=4, send 5 words with no last -> 4 writes, error=1 after the 4th WRITE, cpu_reset stays 1; then start -> error=0 and a reload succeeds.
- WR_GAP=0: 3 words streamed back-to-back -> strobes on alternate cycles, addresses 0xbfc00000, 0xbfc00004, 0xbfc00008.
- Restart from RUN: start -> on the same edge cpu_reset=1, debug=1, done=0; the new image is written from BASE_ADDR again.
- resetn pulled low during the 3rd write -> all outputs return to reset values asynchronously; the next start reloads from 0xbfc00000.
